// File: rtl/bmp180_pkg.sv
// Shared register map, command codes and FSM states for the BMP180 I2C target model.
package bmp180_pkg;

  localparam logic [7:0] REG_ID        = 8'hD0;
  localparam logic [7:0] REG_CALIB     = 8'hAA;
  localparam logic [7:0] REG_CALIB_END = 8'hBF;
  localparam logic [7:0] REG_RESET     = 8'hE0;
  localparam logic [7:0] REG_CTRL      = 8'hF4;
  localparam logic [7:0] REG_OUT_MSB   = 8'hF6;
  localparam logic [7:0] REG_OUT_LSB   = 8'hF7;
  localparam logic [7:0] REG_OUT_XLSB  = 8'hF8;

  localparam logic [7:0] CMD_TEMP   = 8'h2E;
  localparam logic [7:0] CMD_PRES   = 8'h34;
  localparam logic [7:0] SOFT_RESET = 8'hB6;

  localparam int         CALIB_N    = 22;
  localparam logic [4:0] CALIB_LAST = 5'd21;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

endpackage

// File: rtl/bmp180_i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus SCL edge and START/STOP detection.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda_in,
  output logic sda_bit,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  // [1:0] synchronize, [2] holds the previous synchronized value; idle bus is high
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  assign sda_bit  = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/bmp180_i2c_target.sv
// BMP180-style I2C target: byte-level protocol FSM, register map and conversion timer.
module bmp180_i2c_target
  import bmp180_pkg::*;
#(
  parameter logic [6:0]  ADR         = 7'h77,
  parameter logic [7:0]  CHIP_ID     = 8'h55,
  parameter logic [15:0] CONV_CYCLES = 16'd4500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic        calib_we,
  input  logic [4:0]  calib_addr,
  input  logic [7:0]  calib_data,
  input  logic [15:0] ut,
  input  logic [23:0] up,
  output logic        busy
);

  logic       sda_bit, scl_rise, scl_fall, start, stop;
  state_t     state;
  logic [7:0] ptr, sr, byte_in, rd_byte;
  logic [2:0] bitcnt;
  logic       rw, phase;
  logic       wr_stb;
  logic [7:0] wr_addr, wr_data;
  logic [7:0] calib [CALIB_N];
  logic [7:0] ctrl_meas;
  logic [23:0] out;
  logic [15:0] count;
  logic [4:0] cidx;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda_in   (sda_in),
    .sda_bit  (sda_bit),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign byte_in = {sr[6:0], sda_bit};
  assign cidx    = 5'(ptr - REG_CALIB);

  always_comb begin
    rd_byte = 8'h00;
    if (ptr >= REG_CALIB && ptr <= REG_CALIB_END) begin
      rd_byte = calib[cidx];
    end else begin
      case (ptr)
        REG_ID:       rd_byte = CHIP_ID;
        REG_CTRL:     rd_byte = {ctrl_meas[7:6], busy, ctrl_meas[4:0]};
        REG_OUT_MSB:  rd_byte = out[23:16];
        REG_OUT_LSB:  rd_byte = out[15:8];
        REG_OUT_XLSB: rd_byte = out[7:0];
        default:      rd_byte = 8'h00;
      endcase
    end
  end

  // ACK states see two SCL falls: phase 0 drives the ACK, phase 1 ends it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= 8'h00;
      sr      <= 8'h00;
      bitcnt  <= 3'd0;
      rw      <= 1'b0;
      phase   <= 1'b0;
      sda_oe  <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= 8'h00;
      wr_data <= 8'h00;
    end else begin
      wr_stb <= 1'b0;
      if (start) begin
        state  <= ADDR;
        bitcnt <= 3'd0;
        phase  <= 1'b0;
        sda_oe <= 1'b0;
      end else if (stop) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
      end else begin
        case (state)
          ADDR, REG, WDATA: if (scl_rise) begin
            sr     <= byte_in;
            bitcnt <= bitcnt + 3'd1;
            phase  <= 1'b0;
            if (bitcnt == 3'd7) begin
              case (state)
                ADDR: if (byte_in[7:1] == ADR) begin
                  state <= ADDR_ACK;
                  rw    <= byte_in[0];
                end else begin
                  state <= IDLE;
                end
                REG: begin
                  ptr   <= byte_in;
                  state <= REG_ACK;
                end
                default: state <= WDATA_ACK;
              endcase
            end
          end
          ADDR_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
            phase <= 1'b1;
            if (!phase) begin
              sda_oe <= 1'b1;
              if (state == WDATA_ACK) begin
                wr_stb  <= 1'b1;
                wr_addr <= ptr;
                wr_data <= sr;
                ptr     <= ptr + 8'd1;
              end
            end else if (state == ADDR_ACK && rw) begin
              state  <= RDATA;
              sr     <= rd_byte;
              sda_oe <= ~rd_byte[7];
              bitcnt <= 3'd0;
            end else begin
              sda_oe <= 1'b0;
              bitcnt <= 3'd0;
              state  <= (state == ADDR_ACK) ? REG : WDATA;
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bitcnt <= bitcnt + 3'd1;
              phase  <= 1'b0;
              if (bitcnt == 3'd7) state <= RDATA_ACK;
            end else if (scl_fall) begin
              sr     <= {sr[6:0], 1'b0};
              sda_oe <= ~sr[6];
            end
          end
          RDATA_ACK: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oe <= 1'b0;
                phase  <= 1'b1;
              end else begin
                state  <= RDATA;
                sr     <= rd_byte;
                sda_oe <= ~rd_byte[7];
                bitcnt <= 3'd0;
              end
            end else if (scl_rise && phase) begin
              if (sda_bit) state <= IDLE;
              else         ptr   <= ptr + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A new ctrl_meas write restarts the timer; completion loads out and drops busy together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CALIB_N; i++) calib[i] <= 8'h00;
      ctrl_meas <= 8'h00;
      out       <= 24'h0;
      count     <= 16'd0;
      busy      <= 1'b0;
    end else begin
      if (calib_we && calib_addr <= CALIB_LAST) calib[calib_addr] <= calib_data;
      if (wr_stb && wr_addr == REG_CTRL) begin
        ctrl_meas <= wr_data;
        count     <= CONV_CYCLES;
        busy      <= 1'b1;
      end else if (wr_stb && wr_addr == REG_RESET && wr_data == SOFT_RESET) begin
        ctrl_meas <= 8'h00;
        out       <= 24'h0;
        count     <= 16'd0;
        busy      <= 1'b0;
      end else if (busy) begin
        if (count <= 16'd1) begin
          busy  <= 1'b0;
          count <= 16'd0;
          if (ctrl_meas == CMD_TEMP)                   out <= {ut, 8'h00};
          else if (ctrl_meas[4:0] == CMD_PRES[4:0])    out <= up;
        end else begin
          count <= count - 16'd1;
        end
      end
    end
  end

endmodule
